// File: rtl/scan_sched_pkg.sv
// Shared types and constants for the two-scanner sequencer.
// Role codes are also consumed by the HEX display decoder.
package scan_sched_pkg;

    localparam int unsigned ROLE_W  = 3;
    localparam int unsigned MEM_W   = 8;
    localparam int unsigned SWAP_W  = 8;
    localparam int unsigned WDOG_W  = 16;
    localparam int unsigned PCT_MAX = 100;

    localparam logic [ROLE_W-1:0] ROLE_CODE_LOWPWR = 3'd0;
    localparam logic [ROLE_W-1:0] ROLE_CODE_STBY   = 3'd1;
    localparam logic [ROLE_W-1:0] ROLE_CODE_SCAN   = 3'd2;
    localparam logic [ROLE_W-1:0] ROLE_CODE_XFER   = 3'd3;
    localparam logic [ROLE_W-1:0] ROLE_CODE_FLUSH  = 3'd4;

    typedef enum logic [ROLE_W-1:0] {
        ROLE_LOWPWR = ROLE_CODE_LOWPWR,
        ROLE_STBY   = ROLE_CODE_STBY,
        ROLE_SCAN   = ROLE_CODE_SCAN,
        ROLE_XFER   = ROLE_CODE_XFER,
        ROLE_FLUSH  = ROLE_CODE_FLUSH
    } role_t;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } top_state_t;

    // Occupancy above 100 percent is treated as full.
    function automatic logic [MEM_W-1:0] clamp_pct(input logic [MEM_W-1:0] v);
        return (v > MEM_W'(PCT_MAX)) ? MEM_W'(PCT_MAX) : v;
    endfunction

endpackage

// File: rtl/scan_scheduler_stall_watchdog.sv
// Stall watchdog: counts consecutive stall cycles and fires once the limit
// is reached, then restarts counting. The fault flag is sticky until reset.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   stall       : scheduler is in the stall condition this cycle
//   fire_c      : combinational, limit reached on this cycle
//   fault       : registered sticky fault
module stall_watchdog
    import scan_sched_pkg::*;
#(
    parameter int unsigned WDOG_CYC = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic stall,
    output logic fire_c,
    output logic fault
);

    logic [WDOG_W-1:0] cnt_q;

    // Fires on the WDOG_CYC-th consecutive stall cycle.
    assign fire_c = stall && (cnt_q == WDOG_W'(WDOG_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            fault <= 1'b0;
        end else begin
            if (!stall || fire_c) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + WDOG_W'(1);
            end
            if (fire_c) begin
                fault <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/scan_scheduler.sv
// Central sequencer for the two-scanner buffer pair. Chooses the active
// scanner, moves the idle scanner between low power, standby, transfer and
// flush, and issues one-cycle command pulses when a scanner's role changes.
// Optional stall watchdog: define SCAN_SCHED_WATCHDOG_EN.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   start, stop, flush       : user pulses
//   mem_used_0, mem_used_1   : scanner occupancy in percent
//   cmd_scan/stby/xfer/flush/lowpwr[i] : pulse when role_i first becomes X
//   role_0, role_1           : current role codes
//   active_id                : scanning scanner
//   rdy_flush                : a user flush would be accepted
//   swap_count               : completed handoffs (wrapping)
//   stall_fault              : sticky watchdog fault
module scan_scheduler
    import scan_sched_pkg::*;
#(
    parameter int unsigned PREP_LVL = 80,
    parameter int unsigned FULL_LVL = 100,
    parameter int unsigned WDOG_CYC = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        flush,
    input  logic [7:0]  mem_used_0,
    input  logic [7:0]  mem_used_1,
    output logic [1:0]  cmd_scan,
    output logic [1:0]  cmd_stby,
    output logic [1:0]  cmd_xfer,
    output logic [1:0]  cmd_flush,
    output logic [1:0]  cmd_lowpwr,
    output logic [2:0]  role_0,
    output logic [2:0]  role_1,
    output logic        active_id,
    output logic        rdy_flush,
    output logic [7:0]  swap_count,
    output logic        stall_fault
);

    top_state_t        state_q, state_d;
    role_t             role_q [2];
    role_t             role_d [2];
    logic              act_q, act_d;
    logic              rdy_q, rdy_d;
    logic [SWAP_W-1:0] swap_q, swap_d;
    logic [1:0]        scan_d, stby_d, xfer_d, flsh_d, lowp_d;
    logic [MEM_W-1:0]  mem [2];
    logic              idle_id;
    logic              a_prep, a_full;
    logic              wdog_fire_c;
    logic              idle_set;

    assign mem[0]  = clamp_pct(mem_used_0);
    assign mem[1]  = clamp_pct(mem_used_1);
    assign idle_id = ~act_q;
    assign a_prep  = mem[act_q] >= MEM_W'(PREP_LVL);
    assign a_full  = mem[act_q] >= MEM_W'(FULL_LVL);

`ifdef SCAN_SCHED_WATCHDOG_EN
    logic stall_c;

    // Active scanner is full but the idle one cannot take over.
    assign stall_c = (state_q == ST_RUN) && !stop && a_full &&
                     (role_q[idle_id] != ROLE_STBY);

    stall_watchdog #(
        .WDOG_CYC (WDOG_CYC)
    ) u_stall_watchdog (
        .clk    (clk),
        .reset  (reset),
        .stall  (stall_c),
        .fire_c (wdog_fire_c),
        .fault  (stall_fault)
    );
`else
    assign wdog_fire_c = 1'b0;
    assign stall_fault = 1'b0;
`endif

    // Next-state, role and command decode.
    always_comb begin
        state_d   = state_q;
        role_d[0] = role_q[0];
        role_d[1] = role_q[1];
        act_d     = act_q;
        swap_d    = swap_q;
        idle_set  = 1'b0;
        scan_d    = '0;
        stby_d    = '0;
        xfer_d    = '0;
        flsh_d    = '0;
        lowp_d    = '0;

        case (state_q)
            ST_OFF: begin
                if (start) begin
                    state_d   = ST_RUN;
                    role_d[0] = ROLE_SCAN;
                    act_d     = 1'b0;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    role_d[act_q] = ROLE_XFER;
                    state_d       = ST_DRAIN;
                end else if (a_full && (role_q[idle_id] == ROLE_STBY)) begin
                    role_d[act_q]   = ROLE_XFER;
                    role_d[idle_id] = ROLE_SCAN;
                    act_d           = idle_id;
                    swap_d          = swap_q + SWAP_W'(1);
                    idle_set        = 1'b1;
                end else if (wdog_fire_c || (flush && rdy_q)) begin
                    // A stall only freezes the active scanner; the idle one
                    // can still be flushed to break it.
                    role_d[idle_id] = ROLE_FLUSH;
                    idle_set        = 1'b1;
                end

                if (!idle_set) begin
                    if ((role_q[idle_id] == ROLE_LOWPWR) && a_prep) begin
                        role_d[idle_id] = ROLE_STBY;
                    end else if (((role_q[idle_id] == ROLE_XFER) ||
                                  (role_q[idle_id] == ROLE_FLUSH)) &&
                                 (mem[idle_id] == '0)) begin
                        role_d[idle_id] = a_prep ? ROLE_STBY : ROLE_LOWPWR;
                    end
                end
            end

            ST_DRAIN: begin
                // A standby scanner holds no data, so it powers down at once;
                // otherwise wait for the memory to empty.
                for (int i = 0; i < 2; i++) begin
                    if ((role_q[i] == ROLE_STBY) ||
                        (((role_q[i] == ROLE_XFER) || (role_q[i] == ROLE_FLUSH)) &&
                         (mem[i] == '0))) begin
                        role_d[i] = ROLE_LOWPWR;
                    end
                end
                if ((role_d[0] == ROLE_LOWPWR) && (role_d[1] == ROLE_LOWPWR)) begin
                    state_d = ST_OFF;
                end
            end

            default: begin
                state_d = ST_OFF;
            end
        endcase

        // Pulse only on the cycle a role is first entered.
        for (int i = 0; i < 2; i++) begin
            if (role_d[i] != role_q[i]) begin
                scan_d[i] = (role_d[i] == ROLE_SCAN);
                stby_d[i] = (role_d[i] == ROLE_STBY);
                xfer_d[i] = (role_d[i] == ROLE_XFER);
                flsh_d[i] = (role_d[i] == ROLE_FLUSH);
                lowp_d[i] = (role_d[i] == ROLE_LOWPWR);
            end
        end

        rdy_d = (state_d == ST_RUN) &&
                (mem[act_d] >= MEM_W'(PREP_LVL)) &&
                (role_d[~act_d] == ROLE_XFER) &&
                (mem[~act_d] != '0);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_OFF;
            role_q[0]  <= ROLE_LOWPWR;
            role_q[1]  <= ROLE_LOWPWR;
            act_q      <= 1'b0;
            rdy_q      <= 1'b0;
            swap_q     <= '0;
            cmd_scan   <= '0;
            cmd_stby   <= '0;
            cmd_xfer   <= '0;
            cmd_flush  <= '0;
            cmd_lowpwr <= '0;
        end else begin
            state_q    <= state_d;
            role_q[0]  <= role_d[0];
            role_q[1]  <= role_d[1];
            act_q      <= act_d;
            rdy_q      <= rdy_d;
            swap_q     <= swap_d;
            cmd_scan   <= scan_d;
            cmd_stby   <= stby_d;
            cmd_xfer   <= xfer_d;
            cmd_flush  <= flsh_d;
            cmd_lowpwr <= lowp_d;
        end
    end

    assign role_0     = role_q[0];
    assign role_1     = role_q[1];
    assign active_id  = act_q;
    assign rdy_flush  = rdy_q;
    assign swap_count = swap_q;

endmodule

// File: tb/tb_scan_scheduler.sv
// Self-checking bench for scan_scheduler: directed vector table, stall and
// reset sequences, then randomized traffic against a behavioural model.
module tb_scan_scheduler;

    localparam int WDOG = 8;
    localparam int LP = 0, SB = 1, SC = 2, XF = 3, FL = 4;

    logic       clk = 1'b0;
    logic       reset, start, stop, flush;
    logic [7:0] mem_used_0, mem_used_1;
    logic [1:0] cmd_scan, cmd_stby, cmd_xfer, cmd_flush, cmd_lowpwr;
    logic [2:0] role_0, role_1;
    logic       active_id, rdy_flush, stall_fault;
    logic [7:0] swap_count;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: top state 0=off 1=run 2=drain.
    int m_st, m_act, m_rdy, m_swap, m_fault, m_wd;
    int m_r [2];
    int e_cmd [5];   // indexed by role code: mask of scanners entering it

    typedef struct {
        bit st, sp, fl;
        int m0, m1;
        int r0, r1, act, rdy, swp;
        int cscan, cstby, cxfer, cflush, clow;
    } vec_t;
    vec_t tbl [16];

    scan_scheduler #(
        .PREP_LVL (80),
        .FULL_LVL (100),
        .WDOG_CYC (WDOG)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .flush       (flush),
        .mem_used_0  (mem_used_0),
        .mem_used_1  (mem_used_1),
        .cmd_scan    (cmd_scan),
        .cmd_stby    (cmd_stby),
        .cmd_xfer    (cmd_xfer),
        .cmd_flush   (cmd_flush),
        .cmd_lowpwr  (cmd_lowpwr),
        .role_0      (role_0),
        .role_1      (role_1),
        .active_id   (active_id),
        .rdy_flush   (rdy_flush),
        .swap_count  (swap_count),
        .stall_fault (stall_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_r[0] = LP; m_r[1] = LP; m_act = 0; m_rdy = 0;
        m_swap = 0; m_fault = 0; m_wd = 0;
        for (int x = 0; x < 5; x++) e_cmd[x] = 0;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit fl,
                              input int u0, input int u1);
        int m [2];
        int nr [2];
        int a, b, nst, nact;
        bit b_done, stalled, force_fl;
        m[0] = (u0 > 100) ? 100 : u0;
        m[1] = (u1 > 100) ? 100 : u1;
        nr[0] = m_r[0]; nr[1] = m_r[1];
        nst = m_st; nact = m_act; a = m_act; b = 1 - m_act;
        b_done = 0; stalled = 0; force_fl = 0;
        if (m_st == 0) begin
            if (st) begin nst = 1; nr[0] = SC; nact = 0; end
        end else if (m_st == 1) begin
            if (sp) begin
                nr[a] = XF; nst = 2;
            end else if (m[a] >= 100 && m_r[b] == SB) begin
                nr[a] = XF; nr[b] = SC; nact = b;
                m_swap = (m_swap + 1) % 256; b_done = 1;
            end else begin
                stalled = (m[a] >= 100);
`ifdef SCAN_SCHED_WATCHDOG_EN
                if (stalled) begin
                    m_wd++;
                    if (m_wd == WDOG) begin force_fl = 1; m_fault = 1; m_wd = 0; end
                end
`endif
                if (force_fl || (fl && m_rdy != 0)) begin nr[b] = FL; b_done = 1; end
            end
            if (!b_done) begin
                if (m_r[b] == LP && m[a] >= 80) nr[b] = SB;
                else if ((m_r[b] == XF || m_r[b] == FL) && m[b] == 0)
                    nr[b] = (m[a] >= 80) ? SB : LP;
            end
        end else begin
            for (int i = 0; i < 2; i++)
                if (m_r[i] == SB || ((m_r[i] == XF || m_r[i] == FL) && m[i] == 0))
                    nr[i] = LP;
            if (nr[0] == LP && nr[1] == LP) nst = 0;
        end
        if (!stalled) m_wd = 0;
        for (int x = 0; x < 5; x++) e_cmd[x] = 0;
        for (int i = 0; i < 2; i++)
            if (nr[i] != m_r[i]) e_cmd[nr[i]] = e_cmd[nr[i]] | (1 << i);
        m_rdy = (nst == 1 && m[nact] >= 80 && nr[1-nact] == XF && m[1-nact] != 0) ? 1 : 0;
        m_st = nst; m_act = nact; m_r[0] = nr[0]; m_r[1] = nr[1];
    endtask

    task automatic cmp_model();
        chk("model role_0", int'(role_0), m_r[0]);
        chk("model role_1", int'(role_1), m_r[1]);
        chk("model active_id", int'(active_id), m_act);
        chk("model rdy_flush", int'(rdy_flush), m_rdy);
        chk("model swap_count", int'(swap_count), m_swap);
        chk("model stall_fault", int'(stall_fault), m_fault);
        chk("model cmd_scan", int'(cmd_scan), e_cmd[SC]);
        chk("model cmd_stby", int'(cmd_stby), e_cmd[SB]);
        chk("model cmd_xfer", int'(cmd_xfer), e_cmd[XF]);
        chk("model cmd_flush", int'(cmd_flush), e_cmd[FL]);
        chk("model cmd_lowpwr", int'(cmd_lowpwr), e_cmd[LP]);
    endtask

    // Drive after the edge, let the DUT sample, then compare 1 ns later.
    task automatic step(input bit rs, input bit st, input bit sp, input bit fl,
                        input int u0, input int u1);
        reset = rs; start = st; stop = sp; flush = fl;
        mem_used_0 = 8'(u0); mem_used_1 = 8'(u1);
        @(posedge clk);
        if (rs) model_reset();
        else model_step(st, sp, fl, u0, u1);
        #1;
        cmp_model();
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            step(0, tbl[k].st, tbl[k].sp, tbl[k].fl, tbl[k].m0, tbl[k].m1);
            chk($sformatf("row%0d role_0", k), int'(role_0), tbl[k].r0);
            chk($sformatf("row%0d role_1", k), int'(role_1), tbl[k].r1);
            chk($sformatf("row%0d active_id", k), int'(active_id), tbl[k].act);
            chk($sformatf("row%0d rdy_flush", k), int'(rdy_flush), tbl[k].rdy);
            chk($sformatf("row%0d swap_count", k), int'(swap_count), tbl[k].swp);
            chk($sformatf("row%0d cmd_scan", k), int'(cmd_scan), tbl[k].cscan);
            chk($sformatf("row%0d cmd_stby", k), int'(cmd_stby), tbl[k].cstby);
            chk($sformatf("row%0d cmd_xfer", k), int'(cmd_xfer), tbl[k].cxfer);
            chk($sformatf("row%0d cmd_flush", k), int'(cmd_flush), tbl[k].cflush);
            chk($sformatf("row%0d cmd_lowpwr", k), int'(cmd_lowpwr), tbl[k].clow);
        end
    endtask

    function automatic int pick_mem();
        case ($urandom_range(0, 5))
            0: return 0;
            1: return 100;
            2: return 80;
            3: return int'($urandom_range(0, 255));
            default: return int'($urandom_range(0, 110));
        endcase
    endfunction

    initial begin
        //             st sp fl  m0  m1   r0 r1 act rdy swp scan stby xfer flsh low
        tbl[0]  = '{1, 0, 0,   0,   0, SC, LP, 0, 0, 0, 1, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0,  40,   0, SC, LP, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0,  80,   0, SC, SB, 0, 0, 0, 0, 2, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 120,   0, XF, SC, 1, 0, 1, 2, 0, 1, 0, 0};
        tbl[4]  = '{0, 0, 0,  50,  85, XF, SC, 1, 1, 1, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 1,  50,  85, FL, SC, 1, 0, 1, 0, 0, 0, 1, 0};
        tbl[6]  = '{0, 0, 0,   0,  85, SB, SC, 1, 0, 1, 0, 1, 0, 0, 0};
        tbl[7]  = '{0, 0, 1,   0, 100, SC, XF, 0, 0, 2, 1, 0, 2, 0, 0};
        tbl[8]  = '{0, 0, 0, 100,  40, SC, XF, 0, 1, 2, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 100,   0, SC, SB, 0, 0, 2, 0, 2, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 100,   0, XF, SC, 1, 0, 3, 2, 0, 1, 0, 0};
        tbl[11] = '{0, 1, 0,  30,  30, XF, XF, 1, 0, 3, 0, 0, 2, 0, 0};
        tbl[12] = '{1, 0, 0,   0,   0, LP, LP, 1, 0, 3, 0, 0, 0, 0, 3};
        tbl[13] = '{1, 0, 0,   0,   0, SC, LP, 0, 0, 3, 1, 0, 0, 0, 0};
        tbl[14] = '{0, 1, 0,  30,  30, XF, LP, 0, 0, 3, 0, 0, 1, 0, 0};
        tbl[15] = '{0, 0, 0,  30,  30, XF, LP, 0, 0, 3, 0, 0, 0, 0, 0};

        model_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("reset role_0", int'(role_0), LP);
        chk("reset swap_count", int'(swap_count), 0);
        step(0, 0, 1, 0, 0, 0);
        chk("stop in OFF ignored", int'(role_0), LP);

        run_rows(0, 8);

        // Active full while idle scanner still transferring: hold.
`ifdef SCAN_SCHED_WATCHDOG_EN
        for (int k = 0; k < WDOG - 2; k++) begin
            step(0, 0, 0, 0, 100, 40);
            chk("stall hold role_1", int'(role_1), XF);
            chk("stall hold fault", int'(stall_fault), 0);
        end
        step(0, 0, 0, 0, 100, 40);
        chk("wdog stall_fault", int'(stall_fault), 1);
        chk("wdog role_1", int'(role_1), FL);
        chk("wdog cmd_flush", int'(cmd_flush), 2);
`else
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 0, 0, 100, 40);
            chk("stall hold role_0", int'(role_0), SC);
            chk("stall hold role_1", int'(role_1), XF);
            chk("stall hold swap", int'(swap_count), 2);
            chk("stall hold cmd_xfer", int'(cmd_xfer), 0);
        end
`endif

        run_rows(9, 15);

        // Reset mid-drain, with start also asserted.
        step(1, 1, 0, 0, 30, 30);
        chk("drain reset role_0", int'(role_0), LP);
        chk("drain reset swap", int'(swap_count), 0);
        chk("drain reset cmd_lowpwr", int'(cmd_lowpwr), 0);
        chk("drain reset fault", int'(stall_fault), 0);

        for (int n = 0; n < 3000; n++) begin
            bit rs, st, sp, fl;
            int u0, u1;
            rs = ($urandom_range(0, 299) == 0);
            st = ($urandom_range(0, 7) == 0);
            sp = ($urandom_range(0, 49) == 0);
            fl = ($urandom_range(0, 3) == 0);
            u0 = pick_mem();
            u1 = pick_mem();
            step(rs, st, sp, fl, u0, u1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
